// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier normalize/round back end.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    // Wide enough that the two +1 adjustments on a 10-bit signed sum never wrap.
    localparam int EXP_W = 12;
    localparam logic signed [EXP_W-1:0] EXP_ONE = 1;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef struct packed {
        logic                    valid;
        logic                    sign;
        fp_class_e               cls;
        logic [22:0]             mant;
        logic                    guard;
        logic                    sticky;
        logic signed [EXP_W-1:0] exp;
    } stage_a_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; a mantissa carry-out bumps the exponent.
module fp32_round_rne
    import fp_mul_pkg::*;
(
    input  logic [22:0]             mant,
    input  logic                    guard,
    input  logic                    sticky,
    input  logic signed [EXP_W-1:0] exp,
    output logic [22:0]             mant_rnd,
    output logic signed [EXP_W-1:0] exp_rnd,
    output logic                    inexact
);

    logic        round_up;
    logic [23:0] sum;

    assign round_up = guard & (sticky | mant[0]);
    assign sum      = {1'b0, mant} + {23'd0, round_up};
    assign mant_rnd = sum[23] ? 23'd0 : sum[22:0];
    assign exp_rnd  = sum[23] ? (exp + EXP_ONE) : exp;
    assign inexact  = guard | sticky;

endmodule

// File: rtl/fp32_mul_norm_round.sv
// Two-stage back end of an FP32 multiplier: stage A normalizes the raw product,
// stage B rounds, detects overflow/underflow and packs the IEEE-754 result.
module fp32_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter int FLUSH_SUBNORMAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [55:0] in_prod,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic [1:0]  in_special,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    localparam bit FLUSH = (FLUSH_SUBNORMAL != 0);

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic unused_prod_hi;
    assign unused_prod_hi = ^in_prod[55:48];

    // Stage A: normalize so the leading one sits just above the 23-bit fraction.
    logic signed [EXP_W-1:0] exp_ext;
    stage_a_t                a_reg;
    stage_a_t                a_next;

    assign exp_ext = {{(EXP_W-10){in_exp[9]}}, in_exp};

    always_comb begin
        a_next       = '0;
        a_next.valid = in_valid;
        a_next.sign  = in_sign;
        a_next.cls   = fp_class_e'(in_special);
        if (in_prod[47]) begin
            a_next.mant   = in_prod[46:24];
            a_next.guard  = in_prod[23];
            a_next.sticky = |in_prod[22:0];
            a_next.exp    = exp_ext + EXP_ONE;
        end else begin
            a_next.mant   = in_prod[45:23];
            a_next.guard  = in_prod[22];
            a_next.sticky = |in_prod[21:0];
            a_next.exp    = exp_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
        end else if (en) begin
            a_reg <= a_next;
        end
    end

    // Stage B: round, then classify the rounded exponent.
    logic [22:0]             mant_rnd;
    logic signed [EXP_W-1:0] exp_rnd;
    logic                    rnd_inexact;
    logic [31:0]             b_result;
    logic [2:0]              b_flags;

    fp32_round_rne u_round (
        .mant     (a_reg.mant),
        .guard    (a_reg.guard),
        .sticky   (a_reg.sticky),
        .exp      (a_reg.exp),
        .mant_rnd (mant_rnd),
        .exp_rnd  (exp_rnd),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        b_result = '0;
        b_flags  = '0;
        case (a_reg.cls)
            CLS_ZERO: b_result = {a_reg.sign, 31'd0};
            CLS_INF:  b_result = {a_reg.sign, 8'hFF, 23'd0};
            CLS_NAN:  b_result = QNAN;
            default: begin
                if (exp_rnd >= EXP_MAX) begin
                    b_result           = {a_reg.sign, 8'hFF, 23'd0};
                    b_flags[FLAG_OVF] = 1'b1;
                    b_flags[FLAG_INX] = 1'b1;
                end else if (FLUSH && (exp_rnd <= 0)) begin
                    b_result           = {a_reg.sign, 31'd0};
                    b_flags[FLAG_UNF] = 1'b1;
                    b_flags[FLAG_INX] = 1'b1;
                end else begin
                    b_result           = {a_reg.sign, exp_rnd[7:0], mant_rnd};
                    b_flags[FLAG_INX] = rnd_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (en) begin
            out_valid  <= a_reg.valid;
            out_result <= b_result;
            out_flags  <= b_flags;
        end
    end

endmodule
